// File: rtl/ff_pkg.sv
// Shared types and defaults for the D flip-flop cell sequencer.
package ff_pkg;

   localparam int unsigned SEQ_W_DEF = 16;
   localparam int unsigned IDX_W_DEF = 4;
   localparam int unsigned LEN_W_DEF = 5;

   localparam logic [15:0] DEFAULT_PATTERN = 16'b0101001110011111;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      CHECK,
      DONE
   } state_t;

endpackage

// File: rtl/ff_d_seq_ctrl.sv
// Drives a loaded pattern into an external D flip-flop cell bit by bit,
// captures q after each edge and tallies data and complement errors.
module ff_d_seq_ctrl
   import ff_pkg::*;
#(
   parameter int unsigned SEQ_W = SEQ_W_DEF,
   parameter int unsigned IDX_W = IDX_W_DEF,
   parameter int unsigned LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [SEQ_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic             start,
   input  logic             abort,
   output logic             d_out,
   input  logic             q_in,
   input  logic             qb_in,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] bit_idx,
   output logic [SEQ_W-1:0] capture,
   output logic [LEN_W-1:0] mismatch_cnt,
   output logic             pol_err
);

   state_t           state;
   logic [SEQ_W-1:0] pattern_reg;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] len_clamp;
   logic [IDX_W-1:0] idx_next;
   logic             last_bit;

   always_comb begin
      len_clamp = (len > LEN_W'(SEQ_W)) ? LEN_W'(SEQ_W) : len;
      idx_next  = bit_idx + IDX_W'(1);
      last_bit  = ((LEN_W'(bit_idx) + LEN_W'(1)) == len_reg);
   end

   // Outputs are registered: each transition sets the values the next state presents.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         pattern_reg  <= '0;
         len_reg      <= '0;
         bit_idx      <= '0;
         capture      <= '0;
         mismatch_cnt <= '0;
         pol_err      <= 1'b0;
         d_out        <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               d_out <= 1'b0;
               if (load) pattern_reg <= pattern;
               if (start) begin
                  len_reg      <= len_clamp;
                  capture      <= '0;
                  mismatch_cnt <= '0;
                  pol_err      <= 1'b0;
                  bit_idx      <= '0;
                  if (len_clamp == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= DRIVE;
                     busy  <= 1'b1;
                     // a same-cycle load must feed the very first driven bit
                     d_out <= load ? pattern[0] : pattern_reg[0];
                  end
               end
            end
            DRIVE: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  d_out <= 1'b0;
               end else begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  d_out <= 1'b0;
               end else begin
                  capture[bit_idx] <= q_in;
                  if (q_in != pattern_reg[bit_idx]) mismatch_cnt <= mismatch_cnt + LEN_W'(1);
                  if (q_in == qb_in) pol_err <= 1'b1;
                  if (last_bit) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     d_out <= 1'b0;
                  end else begin
                     state   <= DRIVE;
                     bit_idx <= idx_next;
                     d_out   <= pattern_reg[idx_next];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               d_out <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               d_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ff_d_seq_ctrl.md
Name: ff_d_seq_ctrl

Overview:
Sequencer that exercises one D flip-flop cell (ff_d_cell) as a self-checking datapath. It holds a loaded bit pattern and drives the cell's d input one bit at a time. It captures q after each clock edge, compares it against the driven bit, and checks the q/qb complement. Start/busy/done handshake toward a host or test controller.

Parameters:
SEQ_W, 16, pattern length in bits (maximum run length)
IDX_W, 4, bit-index width, clog2(SEQ_W)
LEN_W, 5, length/count width, clog2(SEQ_W)+1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
load  in  1  pattern load strobe, accepted only when not busy
pattern  in  SEQ_W  pattern to load; bit 0 is driven first
len  in  LEN_W  number of bits to run, sampled with start
start  in  1  run request, accepted only in IDLE
abort  in  1  cancel an active run
d_out  out  1  drives ff_d_cell d
q_in  in  1  from ff_d_cell q
qb_in  in  1  from ff_d_cell qb
busy  out  1  high in DRIVE/CHECK
done  out  1  one-cycle pulse at end of a completed run
bit_idx  out  IDX_W  index of the bit currently being driven or checked
capture  out  SEQ_W  q values captured; bit i = q after driving pattern bit i
mismatch_cnt  out  LEN_W  count of bits where captured q != pattern bit
pol_err  out  1  sticky: q_in == qb_in seen in any CHECK of the current run

Behaviour:
- Reset (rst=0, async): state IDLE. pattern_reg, capture, mismatch_cnt, bit_idx, len_reg = 0. d_out, busy, done, pol_err = 0.
- States: IDLE, DRIVE, CHECK, DONE. Encoding is local.
- IDLE: d_out=0. load=1 writes pattern_reg<=pattern. start=1 captures len_reg<=min(len,SEQ_W), clears capture, mismatch_cnt, pol_err, and bit_idx.
  - len_reg==0 -> DONE.
  - Otherwise -> DRIVE.
- Same-cycle load+start in IDLE: both accepted; the run uses the newly loaded pattern.
- DRIVE (1 cycle): d_out=pattern_reg[bit_idx]. The cell samples d at the closing edge. -> CHECK.
- CHECK (1 cycle): d_out is held at the same bit. At the closing edge:
  - capture[bit_idx]<=q_in.
  - If q_in!=pattern_reg[bit_idx], mismatch_cnt+=1.
  - If q_in==qb_in, pol_err<=1.
  - If bit_idx==len_reg-1 -> DONE; else bit_idx+=1 and -> DRIVE.
- DONE (1 cycle): done=1, d_out=0, busy=0. -> IDLE. Results hold until the next accepted start.
- Latency: start accepted at edge 0; done is high in cycle 2*len_reg+1; busy is high for exactly 2*len_reg cycles. len=0 gives done in cycle 1 with busy never asserted.
- load or start while busy: ignored, no side effects. start in DONE is also ignored.
- abort in DRIVE/CHECK: -> IDLE at the next edge with no done pulse. capture, mismatch_cnt, and pol_err keep their partial values. d_out=0 from the next cycle. abort in IDLE/DONE has no effect.
- Reset mid-run: immediate return to reset values. No done pulse.
- mismatch_cnt cannot exceed SEQ_W, so no wrap. len>SEQ_W clamps to SEQ_W.
- Capture bits above len_reg-1 stay 0.

Decomposition:
- Shared package ff_pkg:
  - state enum (IDLE, DRIVE, CHECK, DONE)
  - SEQ_W/IDX_W/LEN_W defaults
  - DEFAULT_PATTERN = 16'b0101001110011111
- ff_d_seq_ctrl is a single module. ff_d_cell is instantiated alongside it in the test harness, not inside the controller.

Test Plan:
- Reset then load DEFAULT_PATTERN, start with len=16 against a correct ff_d_cell:
  - done in cycle 33
  - capture=16'b0101001110011111
  - mismatch_cnt=0, pol_err=0
  - busy high for 32 cycles
- Same run with q_in forced to 0:
  - mismatch_cnt=10 (number of ones in the pattern)
  - capture=0
  - pol_err=1 only if qb_in is also forced to 0
- load 16'hFFFF and start len=4:
  - done in cycle 9
  - capture=16'h000F, mismatch_cnt=0
  - len=20 clamps: done in cycle 33
- start with len=0: done in cycle 1, busy never high, capture=0.
- abort at bit_idx=3 in CHECK with pattern 16'h000F:
  - no done pulse, returns to IDLE
  - capture=16'h0007
  - a subsequent start restarts from bit 0
- load+start in the same IDLE cycle with pattern 16'hA5A5: run uses 16'hA5A5. A load during busy does not alter the pattern. Assert rst=0 mid-run: all outputs go to 0 immediately.
